// File: rtl/time_of_day_counter.sv
// ---------------------------------------------------------------------------
// time_of_day_counter
//
// Purpose:
//   24-hour BCD time-of-day clock (hh:mm:ss). Advances one second on every
//   clock cycle where a 1 Hz tick is present and counting is enabled.
//   Emits one-cycle rollover pulses at minute, hour and day boundaries.
//   Accepts a validated load of a new time. A load always wins over a tick
//   arriving in the same cycle.
//
// Parameters:
//   RESET_HH / RESET_MM / RESET_SS : BCD time loaded while reset is asserted.
//
// Ports:
//   i_clk        : system clock. All state changes on the rising edge.
//   i_reset_n    : asynchronous, active-low reset.
//   i_tick       : one-cycle 1 Hz pulse. Each high cycle counts as one second.
//   i_run        : 1 = count ticks, 0 = hold the current time.
//   i_set_valid  : one-cycle request to load i_set_hh/mm/ss.
//   i_set_hh/mm/ss : BCD time to load.
//   o_hh/mm/ss   : registered BCD current time.
//   o_min_tick   : one-cycle pulse when seconds wrap 59 -> 00.
//   o_hour_tick  : one-cycle pulse when minutes and seconds both wrap.
//   o_day_tick   : one-cycle pulse on the 23:59:59 -> 00:00:00 edge.
//   o_set_ack    : one-cycle pulse when a load request is accepted.
//   o_set_err    : one-cycle pulse when a load request is rejected.
// ---------------------------------------------------------------------------
module time_of_day_counter #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick,
    input  logic       i_run,
    input  logic       i_set_valid,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic [7:0] i_set_ss,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_min_tick,
    output logic       o_hour_tick,
    output logic       o_day_tick,
    output logic       o_set_ack,
    output logic       o_set_err
);

    // Increments a two-digit BCD value and wraps to 00 once it has reached
    // max_val. Because stored values are always in range, the low-digit
    // 9 -> 0 carry covers the 09 -> 10 and 19 -> 20 cases for hours too.
    function automatic logic [7:0] bcd_inc(input logic [7:0] val,
                                           input logic [7:0] max_val);
        logic [7:0] result;
        if (val == max_val) begin
            result = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            result = {val[7:4] + 4'd1, 4'd0};
        end else begin
            result = {val[7:4], val[3:0] + 4'd1};
        end
        return result;
    endfunction

    // A requested value is legal only if both nibbles are decimal digits
    // and the whole value does not exceed the field's maximum.
    function automatic logic bcd_ok(input logic [7:0] val,
                                    input logic [7:0] max_val);
        return (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val <= max_val);
    endfunction

    logic       advance;
    logic       set_ok;
    logic       ss_wrap;
    logic       mm_wrap;
    logic       hh_wrap;
    logic [7:0] ss_next;
    logic [7:0] mm_next;
    logic [7:0] hh_next;

    // Decode the cycle's action and the carry chain. A pending load
    // suppresses the tick, so the tick is discarded rather than queued.
    always_comb begin
        advance = i_tick && i_run && !i_set_valid;
        set_ok  = bcd_ok(i_set_hh, 8'h23) &&
                  bcd_ok(i_set_mm, 8'h59) &&
                  bcd_ok(i_set_ss, 8'h59);
        ss_wrap = (o_ss == 8'h59);
        mm_wrap = (o_mm == 8'h59);
        hh_wrap = (o_hh == 8'h23);
        ss_next = bcd_inc(o_ss, 8'h59);
        mm_next = bcd_inc(o_mm, 8'h59);
        hh_next = bcd_inc(o_hh, 8'h23);
    end

    // Time and pulse registers. All pulses default low every cycle, so each
    // one lasts exactly one cycle. Reset clears any pulse in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hh        <= RESET_HH;
            o_mm        <= RESET_MM;
            o_ss        <= RESET_SS;
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
            o_set_ack   <= 1'b0;
            o_set_err   <= 1'b0;
        end else begin
            o_min_tick  <= 1'b0;
            o_hour_tick <= 1'b0;
            o_day_tick  <= 1'b0;
            o_set_ack   <= 1'b0;
            o_set_err   <= 1'b0;
            if (i_set_valid) begin
                if (set_ok) begin
                    o_hh      <= i_set_hh;
                    o_mm      <= i_set_mm;
                    o_ss      <= i_set_ss;
                    o_set_ack <= 1'b1;
                end else begin
                    o_set_err <= 1'b1;
                end
            end else if (advance) begin
                o_ss       <= ss_next;
                o_min_tick <= ss_wrap;
                if (ss_wrap) begin
                    o_mm        <= mm_next;
                    o_hour_tick <= mm_wrap;
                    if (mm_wrap) begin
                        o_hh       <= hh_next;
                        o_day_tick <= hh_wrap;
                    end
                end
            end
        end
    end

endmodule
